shift_seq: RTL
==============

Name: shift_seq

Overview:
Multi-cycle sequential shift unit for the ALU shift instructions. It applies a one-bit shift step per clock, up to 31 steps, instead of using a full barrel shifter. A start/busy/done handshake sequences the work. Supports logical left, logical right, arithmetic right (sign-replicating, MSB kept) and rotate right.

Parameters:
WIDTH, 32, datapath width in bits
SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; captured with start
data_in  input  WIDTH  operand; captured with start
shamt  input  SHW  shift amount 0..WIDTH-1; captured with start
clear  input  1  synchronous abort
busy  output  1  high while an operation is in flight
done  output  1  one-cycle completion pulse
result  output  WIDTH  final shifted value; held until the next completion

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low: state=IDLE, busy=0, done=0, result=0, acc=0, cnt=0.
  - Reset mid-operation discards the operation immediately. No done is produced.
- All outputs are registered.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=1, done=1.
- IDLE with start=1 (and clear=0):
  - acc<=data_in, op_r<=op, cnt<=shamt.
  - Next state is SHIFT if shamt!=0, otherwise DONE. For shamt=0, result<=data_in on this edge.
- SHIFT, on each edge:
  - acc<=step(acc,op_r), cnt<=cnt-1.
  - When cnt==1, next state is DONE and result<=step(acc,op_r) on the same edge.
- One-bit step definitions:
  - SLL = {acc[W-2:0],0}
  - SRL = {0,acc[W-1:1]}
  - SRA = {acc[W-1],acc[W-1:1]}
  - ROR = {acc[0],acc[W-1:1]}
- DONE: lasts exactly one cycle, then IDLE. start is ignored in DONE.
- Latency: done is high in the cycle following edge number shamt+1, counting the start-sampling edge as edge 1.
- Throughput: the next start is accepted in the first IDLE cycle after done.
- start while busy=1: ignored, not queued.
- clear: highest priority over start and FSM progress.
  - Next state IDLE, busy<=0, done<=0.
  - result keeps its previous value.
  - start in the same cycle as clear is ignored.
  - clear in IDLE has no effect.
- cnt never underflows; it is only decremented in SHIFT with cnt>=1.
- result changes only on the edge entering DONE, or on reset.

Decomposition:
- Package shift_seq_pkg:
  - op encodings OP_SLL/OP_SRL/OP_SRA/OP_ROR
  - state enum IDLE/SHIFT/DONE
  - default WIDTH/SHW constants
- One combinational sub-module, shift_step: one-bit step selected by op, WIDTH-parameterised.
- FSM, counter and registers live in shift_seq.

Test Plan:
1. SRA, data_in=0x8000_0000, shamt=4 -> result=0xF800_0000; done pulses once, 5 edges after start; busy high for 5 cycles.
2. SRL, data_in=0x8000_0000, shamt=31 -> result=0x0000_0001; done 32 edges after start.
3. SLL, data_in=0x0000_0001, shamt=0 -> done after 1 edge, result=0x0000_0001. Then ROR, 0x0000_0001, shamt=1 -> result=0x8000_0000.
4. Busy rejection: start SLL 0x1 shamt=3, then assert start with other operands every busy cycle -> single done, result=0x0000_0008; later starts ignored.
5. Clear mid-op: complete SRA 0xF000_0000 shamt=4 (result=0xFF00_0000); start SRL shamt=10; clear on cycle 3 -> busy=0 next cycle, no done, result stays 0xFF00_0000. Then a new SLL 0x1 shamt=2 -> result=0x4.
6. Async reset mid-op: drop rst_n between edges during SHIFT -> busy/done/result go to 0 without a clock edge; after release, the FSM is IDLE and accepts start.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings and default sizes for the sequential shift unit.
package shift_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift/rotate step selected by op.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  op_e              op,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = acc;
    unique case (op)
      OP_SLL: nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRL: nxt = {1'b0, acc[WIDTH-1:1]};
      OP_SRA: nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_ROR: nxt = {acc[0], acc[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift unit: one bit per clock, start/busy/done handshake, synchronous clear.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc(acc_q),
    .op (op_q),
    .nxt(step_val)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (clear) begin
      // Abort wins over everything; result is deliberately left untouched.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_d = data_in;
            op_d  = op_e'(op);
            cnt_d = shamt;
            if (shamt == '0) begin
              state_d  = DONE;
              result_d = data_in;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_d = step_val;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_d  = DONE;
            result_d = step_val;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
